// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: steps an iterative AES-128 datapath through INIT, ten KSUB/SUB/MIX rounds and DONE
module aes_round_ctrl #(
    parameter int SBOX_COLS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       init_we,
    output logic       sbox_sel,
    output logic [1:0] col_sel,
    output logic       ksub_we,
    output logic       sub_we,
    output logic       round_we,
    output logic       key_we,
    output logic       last_round,
    output logic [3:0] round,
    output logic [7:0] rcon
);
    typedef enum logic [2:0] {IDLE, INIT, KSUB, SUB, MIX, DONE} state_t;
    localparam logic [1:0] STEP = 2'(SBOX_COLS);
    localparam logic [1:0] LAST_COL = 2'(4 - SBOX_COLS);
    if (SBOX_COLS != 1 && SBOX_COLS != 2 && SBOX_COLS != 4) begin : g_bad_cols
        $error("SBOX_COLS must be 1, 2 or 4");
    end
    state_t     r_state, w_state;
    logic [3:0] r_round, w_round;
    logic [7:0] r_rcon, w_rcon;
    logic [1:0] r_col, w_col;
    logic       r_load_q;
    logic       w_start;
    logic [7:0] w_xtime;
    assign w_start = r_load_q & ~load;
    assign w_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_round  <= '0;
            r_rcon   <= '0;
            r_col    <= '0;
            r_load_q <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_round  <= w_round;
            r_rcon   <= w_rcon;
            r_col    <= w_col;
            r_load_q <= load;
        end
    end
    always_comb begin
        w_state = r_state;
        w_round = r_round;
        w_rcon  = r_rcon;
        w_col   = r_col;
        case (r_state)
            IDLE, DONE: if (w_start) begin
                w_state = INIT;
                w_round = '0;
                w_rcon  = '0;
            end
            INIT: begin
                w_state = KSUB;
                w_round = 4'd1;
                w_rcon  = 8'h01;
            end
            KSUB: begin
                w_state = SUB;
                w_col   = '0;
            end
            SUB: begin
                w_col   = r_col + STEP;
                w_state = (r_col == LAST_COL) ? MIX : SUB;
            end
            MIX: if (r_round == 4'd10) w_state = DONE;
            else begin
                w_state = KSUB;
                w_round = r_round + 4'd1;
                w_rcon  = w_xtime;
            end
            default: w_state = IDLE;
        endcase
        // load while running aborts; load in DONE acknowledges the result
        if (load && r_state != IDLE) begin
            w_state = IDLE;
            w_round = '0;
            w_rcon  = '0;
            w_col   = '0;
        end
    end
    assign busy       = r_state inside {INIT, KSUB, SUB, MIX};
    assign done       = r_state == DONE;
    assign init_we    = r_state == INIT;
    assign ksub_we    = r_state == KSUB;
    assign sbox_sel   = r_state == SUB;
    assign sub_we     = r_state == SUB;
    assign col_sel    = (r_state == SUB) ? r_col : 2'd0;
    assign round_we   = r_state == MIX;
    assign key_we     = r_state == MIX;
    assign last_round = (r_state == MIX) && (r_round == 4'd10);
    assign round      = r_round;
    assign rcon       = r_rcon;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: runs SBOX_COLS=1,2,4 side by side against a cycle-index reference model
module tb_aes_round_ctrl;
    logic clk = 0;
    logic rst = 0;
    logic load = 0;
    int checks = 0;
    int errors = 0;
    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [2:0][22:0] act;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // mode 0 idle, 1 running (t = cycles since INIT), 2 done
    function automatic logic [22:0] expv(input int mode, input int t, input int s);
        int n, k, r, p;
        logic b, d, iw, ss, kw, sw, rw, lr;
        logic [1:0] cs;
        logic [3:0] rd;
        logic [7:0] rc;
        n = 4 / s;
        {b, d, iw, ss, kw, sw, rw, lr, cs, rd, rc} = '0;
        if (mode == 2) begin
            d  = 1;
            rd = 4'd10;
            rc = 8'h36;
        end else if (mode == 1) begin
            b = 1;
            if (t == 0) iw = 1;
            else begin
                k  = t - 1;
                r  = k / (n + 2) + 1;
                p  = k % (n + 2);
                rd = 4'(r);
                rc = rc_tab[r-1];
                if (p == 0) kw = 1;
                else if (p <= n) begin
                    ss = 1;
                    sw = 1;
                    cs = 2'((p - 1) * s);
                end else begin
                    rw = 1;
                    lr = (r == 10);
                end
            end
        end
        return {b, d, iw, ss, cs, kw, sw, rw, rw, lr, rd, rc};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = 1 << g;
        localparam int BLEN = 1 + 10 * (2 + 4 / S);
        logic busy, done, iw, ss, kw, sw, rw, kyw, lr;
        logic [1:0] cs;
        logic [3:0] rd;
        logic [7:0] rc;
        int mode = 0;
        int t = 0;
        int len = 0;
        logic lq = 0;
        aes_round_ctrl #(.SBOX_COLS(S)) dut (
            .clk(clk), .rst(rst), .load(load), .busy(busy), .done(done),
            .init_we(iw), .sbox_sel(ss), .col_sel(cs), .ksub_we(kw), .sub_we(sw),
            .round_we(rw), .key_we(kyw), .last_round(lr), .round(rd), .rcon(rc)
        );
        assign act[g] = {busy, done, iw, ss, cs, kw, sw, rw, kyw, lr, rd, rc};
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode <= 0;
                t    <= 0;
                lq   <= 0;
            end else begin
                if (mode == 1) begin
                    if (load) mode <= 0;
                    else begin
                        t <= t + 1;
                        if (t + 1 == BLEN) mode <= 2;
                    end
                end else if (lq && !load) begin
                    mode <= 1;
                    t    <= 0;
                end else if (mode == 2 && load) mode <= 0;
                lq <= load;
            end
        end
        always @(negedge clk) begin
            check($sformatf("out_s%0d", S), 32'(act[g]), 32'(expv(mode, t, S)));
            check($sformatf("excl_s%0d", S),
                  32'($countones({iw, kw, sw, rw}) <= 1 && (!kyw || rw) && (!ss || sw)), 32'd1);
            if (busy) len <= len + 1;
            else begin
                if (len != 0 && done) check($sformatf("busylen_s%0d", S), 32'(len), 32'(BLEN));
                len <= 0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_out", 32'(act[0]), 32'd0);
        rst = 1;
        load = 1;
        repeat (256) @(negedge clk);
        load = 0;
        for (int i = 0; i < 5 && !act[0][22]; i++) @(negedge clk);
        check("start_busy", 32'(act[0][22]), 32'd1);
        for (int i = 0; i < 100 && act[0][22]; i++) @(negedge clk);
        check("first_done", 32'(act[0][21]), 32'd1);
        check("first_round", 32'(act[0][11:8]), 32'd10);
        repeat (200) @(negedge clk);
        check("done_hold", 32'(act[0][21]), 32'd1);
        load = 1;
        @(negedge clk);
        check("done_clear", 32'(act[0][21]), 32'd0);
        load = 0;
        for (int i = 0; i < 200 && !(act[0][11:8] == 5 && act[0][15] && act[0][18:17] == 2); i++)
            @(negedge clk);
        check("reach_r5c2", 32'(act[0][11:8] == 5 && act[0][15] && act[0][18:17] == 2), 32'd1);
        load = 1;
        @(negedge clk);
        check("abort_busy", 32'(act[0][22]), 32'd0);
        check("abort_round", 32'(act[0][11:8]), 32'd0);
        check("abort_done", 32'(act[0][21]), 32'd0);
        load = 0;
        for (int i = 0; i < 100 && !act[0][21]; i++) @(negedge clk);
        check("rerun_done", 32'(act[0][21]), 32'd1);
        load = 1;
        @(negedge clk);
        load = 0;
        for (int i = 0; i < 100 && act[0][11:8] != 7; i++) @(negedge clk);
        check("reach_r7", 32'(act[0][11:8]), 32'd7);
        #2 rst = 0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("async_rst_%0d", i), 32'(act[i]), 32'd0);
        @(negedge clk);
        rst = 1;
        repeat (20) @(negedge clk);
        check("no_start", 32'(act[0][22]), 32'd0);
        load = 1;
        @(negedge clk);
        load = 0;
        for (int i = 0; i < 100 && !act[0][21]; i++) @(negedge clk);
        check("pulse_done", 32'(act[0][21]), 32'd1);
        repeat (40) begin
            load = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 70)) @(negedge clk);
        end
        load = 0;
        repeat (80) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
